// File: rtl/memory_access_ctrl.sv
// Initiator-side controller for a single-port synchronous word memory.
// Optional post-reset clear, then serialised read/write requests over valid/ready.
module memory_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned WORD_DEPTH = 4,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [WORD_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_adrs,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  mem_we_n,
    output logic [ADDR_WIDTH-1:0] mem_adrs,
    output logic [WORD_WIDTH-1:0] mem_d_in,
    input  logic [WORD_WIDTH-1:0] mem_q
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(WORD_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WRITE   = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_WAIT = 3'd4
    } state_t;

    localparam state_t RST_STATE = INIT_EN ? S_INIT : S_IDLE;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        init_cnt, init_cnt_nxt;
    logic [LAT_W-1:0]        lat_cnt, lat_cnt_nxt;
    logic                    req_ready_nxt;
    logic                    rsp_valid_nxt;
    logic [WORD_WIDTH-1:0]   rsp_rdata_nxt;
    logic                    init_done_nxt;
    logic                    mem_we_n_nxt;
    logic [ADDR_WIDTH-1:0]   mem_adrs_nxt;
    logic [WORD_WIDTH-1:0]   mem_d_in_nxt;
    logic                    accept_c;

    assign accept_c = (state == S_IDLE) && req_valid && req_ready;

    // State and registered outputs; reset forces write-enable and response low at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            init_cnt  <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
            mem_we_n  <= 1'b1;
            mem_adrs  <= '0;
            mem_d_in  <= '0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            lat_cnt   <= lat_cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            init_done <= init_done_nxt;
            mem_we_n  <= mem_we_n_nxt;
            mem_adrs  <= mem_adrs_nxt;
            mem_d_in  <= mem_d_in_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:    if (init_cnt == INIT_LAST) state_nxt = S_IDLE;
            S_IDLE:    if (accept_c) state_nxt = req_wr ? S_WRITE : S_RD_ADDR;
            S_WRITE:   state_nxt = S_IDLE;
            S_RD_ADDR: state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (lat_cnt == '0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output lookahead: values computed here are what the outputs show in the next state
    always_comb begin
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        init_done_nxt = init_done;
        mem_we_n_nxt  = 1'b1;
        mem_adrs_nxt  = mem_adrs;
        mem_d_in_nxt  = mem_d_in;
        init_cnt_nxt  = init_cnt;
        lat_cnt_nxt   = lat_cnt;
        case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    init_done_nxt = 1'b1;
                    req_ready_nxt = 1'b1;
                end else begin
                    mem_we_n_nxt = 1'b0;
                    mem_adrs_nxt = init_cnt[ADDR_WIDTH-1:0];
                    mem_d_in_nxt = INIT_VALUE;
                    init_cnt_nxt = init_cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                init_done_nxt = 1'b1;
                if (accept_c) begin
                    mem_adrs_nxt = req_adrs;
                    if (req_wr) begin
                        mem_we_n_nxt = 1'b0;
                        mem_d_in_nxt = req_wdata;
                    end
                end else begin
                    req_ready_nxt = 1'b1;
                end
            end
            S_WRITE: req_ready_nxt = 1'b1;
            S_RD_ADDR: lat_cnt_nxt = LAT_LOAD;
            S_RD_WAIT: begin
                if (lat_cnt == '0) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = mem_q;
                    req_ready_nxt = 1'b1;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Scoreboard bench: DUT A (defaults) and DUT B (MEM_LAT=2, INIT_EN=0), each with a behavioural memory.
module tb_memory_access_ctrl;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    logic       rst_a, req_valid_a, req_ready_a, req_wr_a, rsp_valid_a, init_done_a, mem_we_n_a;
    logic [1:0] req_adrs_a, mem_adrs_a;
    logic [7:0] req_wdata_a, rsp_rdata_a, mem_d_in_a, mem_q_a;
    logic       rst_b, req_valid_b, req_ready_b, req_wr_b, rsp_valid_b, init_done_b, mem_we_n_b;
    logic [1:0] req_adrs_b, mem_adrs_b;
    logic [7:0] req_wdata_b, rsp_rdata_b, mem_d_in_b, mem_q_b;

    logic [7:0] mem_a[4];
    logic [7:0] mem_b[4];
    logic [7:0] qb1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_access_ctrl dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_wr(req_wr_a), .req_adrs(req_adrs_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .init_done(init_done_a),
        .mem_we_n(mem_we_n_a), .mem_adrs(mem_adrs_a), .mem_d_in(mem_d_in_a), .mem_q(mem_q_a)
    );

    memory_access_ctrl #(.MEM_LAT(2), .INIT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_wr(req_wr_b), .req_adrs(req_adrs_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .init_done(init_done_b),
        .mem_we_n(mem_we_n_b), .mem_adrs(mem_adrs_b), .mem_d_in(mem_d_in_b), .mem_q(mem_q_b)
    );

    // Single-port memories with registered read: latency 1 for A, 2 for B
    always @(posedge clk) begin
        if (!mem_we_n_a) mem_a[mem_adrs_a] <= mem_d_in_a;
        mem_q_a <= mem_a[mem_adrs_a];
        if (!mem_we_n_b) mem_b[mem_adrs_b] <= mem_d_in_b;
        qb1     <= mem_b[mem_adrs_b];
        mem_q_b <= qb1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: every response pulse must match the oldest expected read, in data and cycle
    always @(negedge clk) begin
        if (rsp_valid_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rsp_a_unexpected actual=%0h expected=no_response", rsp_rdata_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if (rsp_rdata_a !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rsp_a actual=%0h@%0d expected=%0h@%0d", rsp_rdata_a, cyc, e.data, e.cyc);
                end
            end
        end
        if (rsp_valid_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rsp_b_unexpected actual=%0h expected=no_response", rsp_rdata_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if (rsp_rdata_b !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rsp_b actual=%0h@%0d expected=%0h@%0d", rsp_rdata_b, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // Issue one request and return the cycle count right after its accepting edge
    task automatic do_req(input bit sel, input bit wr, input logic [1:0] a, input logic [7:0] wd,
                          input bit push, input logic [7:0] exp, output int acc);
        acc = -1;
        @(negedge clk);
        if (sel) begin
            req_valid_b = 1'b1; req_wr_b = wr; req_adrs_b = a; req_wdata_b = wd;
        end else begin
            req_valid_a = 1'b1; req_wr_a = wr; req_adrs_a = a; req_wdata_a = wd;
        end
        for (int n = 0; n < 40; n++) begin
            if (sel ? req_ready_b : req_ready_a) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
        else if (push && !wr) begin
            exp_t e;
            e.data = exp;
            e.cyc  = acc + 1 + (sel ? 2 : 1);
            if (sel) q_b.push_back(e);
            else q_a.push_back(e);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (q_a.size() != 0 || q_b.size() != 0); n++) @(negedge clk);
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Release reset on A and follow the clearing sweep
    task automatic init_seq_a();
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("init_we_n", mem_we_n_a, 0);
            chk("init_adrs", mem_adrs_a, i);
            chk("init_d_in", mem_d_in_a, 0);
            chk("init_ready", req_ready_a, 0);
        end
        @(negedge clk);
        chk("init_end_we_n", mem_we_n_a, 1);
        chk("init_end_done", init_done_a, 1);
        chk("init_end_ready", req_ready_a, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, rel;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'hEE;
            mem_b[i] = 8'h00;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        req_valid_a = 1'b0; req_wr_a = 1'b0; req_adrs_a = '0; req_wdata_a = '0;
        req_valid_b = 1'b0; req_wr_b = 1'b0; req_adrs_b = '0; req_wdata_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready_a, 0);
        chk("rst_rsp_valid", rsp_valid_a, 0);
        chk("rst_rdata", rsp_rdata_a, 0);
        chk("rst_done", init_done_a, 0);
        chk("rst_we_n", mem_we_n_a, 1);
        chk("rst_adrs", mem_adrs_a, 0);
        chk("rst_d_in", mem_d_in_a, 0);
        init_seq_a();

        for (int i = 0; i < 4; i++) do_req(0, 0, 2'(i), 8'h00, 1, 8'h00, acc);
        drain();

        do_req(0, 1, 2'd2, 8'hA5, 0, 8'h00, acc);
        chk("wr_we_n_low", mem_we_n_a, 0);
        chk("wr_adrs", mem_adrs_a, 2);
        chk("wr_d_in", mem_d_in_a, 8'hA5);
        chk("wr_ready_low", req_ready_a, 0);
        @(posedge clk); #1;
        chk("wr_we_n_high", mem_we_n_a, 1);
        chk("wr_ready_back", req_ready_a, 1);
        do_req(0, 0, 2'd2, 8'h00, 1, 8'hA5, acc);
        drain();

        prev = -1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] wd;
            wd = 8'h11 * 8'(i + 1);
            do_req(0, 1, 2'(i), wd, 0, 8'h00, acc);
            if (prev >= 0) chk("b2b_wr_spacing", acc - prev, 2);
            prev = acc;
        end
        for (int i = 0; i < 4; i++) do_req(0, 0, 2'(i), 8'h00, 1, 8'h11 * 8'(i + 1), acc);
        drain();

        // Request held from reset release is accepted only after the clear
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        fork
            do_req(0, 1, 2'd1, 8'hFF, 0, 8'h00, acc);
            begin
                @(negedge clk);
                rel = cyc;
                rst_a = 1'b0;
            end
        join
        chk("init_req_accept_cyc", acc - rel, 6);
        @(posedge clk); #1;
        chk("init_req_we_n_once", mem_we_n_a, 1);
        do_req(0, 0, 2'd1, 8'h00, 1, 8'hFF, acc);
        do_req(0, 0, 2'd0, 8'h00, 1, 8'h00, acc);
        drain();

        // Reset during RD_WAIT: no response, immediate outputs, init restarts
        do_req(0, 0, 2'd1, 8'h00, 0, 8'h00, acc);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("midrd_we_n", mem_we_n_a, 1);
        chk("midrd_rsp_valid", rsp_valid_a, 0);
        chk("midrd_done", init_done_a, 0);
        chk("midrd_ready", req_ready_a, 0);
        init_seq_a();

        // Reset during WRITE drops write enable asynchronously
        do_req(0, 1, 2'd3, 8'h77, 0, 8'h00, acc);
        #2;
        rst_a = 1'b1;
        #1;
        chk("midwr_we_n", mem_we_n_a, 1);
        init_seq_a();
        do_req(0, 0, 2'd3, 8'h00, 1, 8'h00, acc);
        drain();

        // DUT B: no init sweep, longer read latency
        chk("b_rst_ready", req_ready_b, 0);
        chk("b_rst_done", init_done_b, 0);
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b_ready_first", req_ready_b, 1);
        chk("b_done_first", init_done_b, 1);
        chk("b_we_n", mem_we_n_b, 1);
        do_req(1, 1, 2'd0, 8'h3C, 0, 8'h00, acc);
        do_req(1, 0, 2'd0, 8'h00, 1, 8'h3C, acc);
        prev = acc;
        do_req(1, 0, 2'd0, 8'h00, 1, 8'h3C, acc);
        chk("b_rd_spacing", acc - prev, 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
